// File: rtl/digipot_pkg.sv
// Shared types and constants for the digital-potentiometer command sequencer.
// Holds the FSM encoding, the pot-select codes, the default timing and the shadow read helper.
package digipot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_XFER  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  localparam logic [1:0] POT_CS1     = 2'd0;
  localparam logic [1:0] POT_CS2     = 2'd1;
  localparam logic [1:0] POT_CS3     = 2'd2;
  localparam logic [1:0] POT_ILLEGAL = 2'd3;

  localparam int         SETUP_CYC_DEF = 2;
  localparam int         XFER_CYC_DEF  = 40;
  localparam int         GAP_CYC_DEF   = 4;
  localparam logic [7:0] RST_VAL_DEF   = 8'h80;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // The illegal select reads as zero, so callers never index past the third pot.
  function automatic logic [7:0] shadow_pick(input logic [2:0][7:0] sh, input logic [1:0] sel);
    logic [7:0] v;
    case (sel)
      POT_CS1: v = sh[0];
      POT_CS2: v = sh[1];
      POT_CS3: v = sh[2];
      default: v = 8'h00;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/digipot_phase_timer.sv
// Loadable down-counter that times one sequencer phase.
// A load of N makes done pulse in the N-th cycle after the load edge; a load of 0 keeps it idle.
module digipot_phase_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)               cnt_d = load_val;
    else if (cnt_q != '0)   cnt_d = cnt_q - W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign done = (cnt_q == W'(1));

endmodule

// File: rtl/digipot_cmd_seq.sv
// Command sequencer feeding the three-pot serial controller: shadow registers, timed start pulses, bulk refresh.
// Optional macro DIGIPOT_SKIP_SAME_EN: legal commands that match the current shadow value produce no write.
module digipot_cmd_seq
  import digipot_pkg::*;
#(
  parameter int         SETUP_CYC = SETUP_CYC_DEF,
  parameter int         XFER_CYC  = XFER_CYC_DEF,
  parameter int         GAP_CYC   = GAP_CYC_DEF,
  parameter logic [7:0] RST_VAL   = RST_VAL_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_sel,
  input  logic [7:0] cmd_data,
  input  logic       refresh,
  output logic [1:0] mux,
  output logic       ctrl,
  output logic [7:0] dato,
  output logic       busy,
  output logic       err,
  input  logic       err_clr,
  output logic [7:0] shadow0,
  output logic [7:0] shadow1,
  output logic [7:0] shadow2
);

  localparam int CNT_W = $clog2(max3(SETUP_CYC, XFER_CYC, GAP_CYC)) + 1;

  state_t          state_q, state_d;
  logic [1:0]      mux_q, mux_d;
  logic [7:0]      dato_q, dato_d;
  logic            ctrl_q, ctrl_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            refresh_pend_q, refresh_pend_d;
  logic            refresh_act_q, refresh_act_d;
  logic [1:0]      idx_q, idx_d;
  logic [2:0][7:0] shadow_q, shadow_d;

  logic             accept;
  logic             skip_same;
  logic [7:0]       cur_shadow;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_done;

  digipot_phase_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  assign accept     = cmd_valid && cmd_ready_q;
  assign cur_shadow = shadow_pick(shadow_q, cmd_sel);

`ifdef DIGIPOT_SKIP_SAME_EN
  assign skip_same = (cmd_data == cur_shadow);
`else
  assign skip_same = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d        = state_q;
    mux_d          = mux_q;
    dato_d         = dato_q;
    err_d          = err_q;
    refresh_pend_d = refresh_pend_q;
    refresh_act_d  = refresh_act_q;
    idx_d          = idx_q;
    shadow_d       = shadow_q;
    tmr_load       = 1'b0;
    tmr_val        = '0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (cmd_sel == POT_ILLEGAL) begin
            err_d = 1'b1;
          end else begin
            for (int i = 0; i < 3; i++) begin
              if (cmd_sel == 2'(i)) shadow_d[i] = cmd_data;
            end
            if (!skip_same) begin
              state_d       = ST_SETUP;
              mux_d         = cmd_sel;
              dato_d        = cmd_data;
              refresh_act_d = 1'b0;
              tmr_load      = 1'b1;
              tmr_val       = CNT_W'(SETUP_CYC);
            end
          end
        end else if (refresh_pend_q) begin
          refresh_pend_d = 1'b0;
          refresh_act_d  = 1'b1;
          idx_d          = 2'd0;
          state_d        = ST_SETUP;
          mux_d          = POT_CS1;
          dato_d         = shadow_q[0];
          tmr_load       = 1'b1;
          tmr_val        = CNT_W'(SETUP_CYC);
        end
      end
      ST_SETUP: begin
        if (tmr_done) begin
          state_d  = ST_XFER;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(XFER_CYC);
        end
      end
      ST_XFER: begin
        if (tmr_done) begin
          state_d  = ST_GAP;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(GAP_CYC);
        end
      end
      ST_GAP: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          if (refresh_act_q && idx_q < 2'd2) begin
            idx_d    = idx_q + 2'd1;
            state_d  = ST_SETUP;
            mux_d    = idx_q + 2'd1;
            dato_d   = shadow_pick(shadow_q, idx_q + 2'd1);
            tmr_val  = CNT_W'(SETUP_CYC);
          end else begin
            state_d       = ST_IDLE;
            refresh_act_d = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A pulse during a running refresh folds into one pending rerun.
    if (refresh) refresh_pend_d = 1'b1;
    if (err_clr) err_d = 1'b0;

    cmd_ready_d = (state_d == ST_IDLE) && !refresh_pend_d;
    busy_d      = (state_d != ST_IDLE);
    // ctrl trails the state by one cycle, giving the SETUP_CYC+1 start latency.
    ctrl_d      = (state_q != ST_XFER);
  end

  // NOTE: the three shadow bytes are reset explicitly; they are plain flops, not a RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      mux_q          <= 2'd0;
      dato_q         <= 8'h00;
      ctrl_q         <= 1'b1;
      busy_q         <= 1'b0;
      err_q          <= 1'b0;
      cmd_ready_q    <= 1'b0;
      refresh_pend_q <= 1'b0;
      refresh_act_q  <= 1'b0;
      idx_q          <= 2'd0;
      shadow_q       <= {3{RST_VAL}};
    end else begin
      state_q        <= state_d;
      mux_q          <= mux_d;
      dato_q         <= dato_d;
      ctrl_q         <= ctrl_d;
      busy_q         <= busy_d;
      err_q          <= err_d;
      cmd_ready_q    <= cmd_ready_d;
      refresh_pend_q <= refresh_pend_d;
      refresh_act_q  <= refresh_act_d;
      idx_q          <= idx_d;
      shadow_q       <= shadow_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign mux       = mux_q;
  assign ctrl      = ctrl_q;
  assign dato      = dato_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign shadow0   = shadow_q[0];
  assign shadow1   = shadow_q[1];
  assign shadow2   = shadow_q[2];

endmodule

// File: tb/tb_digipot_cmd_seq.sv
// Scoreboard bench for digipot_cmd_seq: stimulus queues expected writes, a monitor checks each ctrl pulse.
// Honours DIGIPOT_SKIP_SAME_EN when choosing the expectation for a same-value command.
module tb_digipot_cmd_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_sel;
  logic [7:0] cmd_data;
  logic       refresh;
  logic [1:0] mux;
  logic       ctrl;
  logic [7:0] dato;
  logic       busy, err, err_clr;
  logic [7:0] shadow0, shadow1, shadow2;

  typedef struct {
    logic [1:0] mux;
    logic [7:0] dato;
  } wr_t;

  wr_t exp_q[$];
  int  high_q[$];
  int  errors = 0;
  int  checks = 0;

  digipot_cmd_seq dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_sel   (cmd_sel),
    .cmd_data  (cmd_data),
    .refresh   (refresh),
    .mux       (mux),
    .ctrl      (ctrl),
    .dato      (dato),
    .busy      (busy),
    .err       (err),
    .err_clr   (err_clr),
    .shadow0   (shadow0),
    .shadow1   (shadow1),
    .shadow2   (shadow2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [1:0] m, input logic [7:0] d);
    wr_t w;
    w.mux  = m;
    w.dato = d;
    exp_q.push_back(w);
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: cmd_ready still %0b after %0d cycles", cmd_ready, n);
    end
  endtask

  task automatic send_cmd(input logic [1:0] sel, input logic [7:0] data);
    wait_ready();
    cmd_valid = 1'b1;
    cmd_sel   = sel;
    cmd_data  = data;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic pulse_refresh();
    @(negedge clk);
    refresh = 1'b1;
    @(posedge clk);
    #1 refresh = 1'b0;
  endtask

  // Monitor: every ctrl fall pops one expected write; every rise checks the low time and stability.
  logic       ctrl_prev;
  int         low_cnt, high_cnt;
  logic [1:0] p_mux;
  logic [7:0] p_dato;
  wr_t        mw;

  always @(negedge clk) begin
    if (rst) begin
      ctrl_prev = 1'b1;
      low_cnt   = 0;
      high_cnt  = 0;
    end else begin
      if (ctrl_prev && !ctrl) begin
        high_q.push_back(high_cnt);
        high_cnt = 0;
        low_cnt  = 1;
        p_mux    = mux;
        p_dato   = dato;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: mux=%0d dato=%0h with no write queued", mux, dato);
        end else begin
          mw = exp_q.pop_front();
          check("write_mux", 32'(mux), 32'(mw.mux));
          check("write_dato", 32'(dato), 32'(mw.dato));
        end
      end else if (!ctrl) begin
        low_cnt++;
      end else begin
        if (!ctrl_prev) begin
          check("ctrl_low_len", low_cnt, 40);
          check("mux_stable", 32'(mux), 32'(p_mux));
          check("dato_stable", 32'(dato), 32'(p_dato));
        end
        high_cnt++;
      end
      ctrl_prev = ctrl;
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int n;
    logic saw;

    rst = 1'b1; cmd_valid = 1'b0; cmd_sel = 2'd0; cmd_data = 8'h00;
    refresh = 1'b0; err_clr = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(cmd_ready), 0);
    check("rst_ctrl", 32'(ctrl), 1);
    check("rst_mux", 32'(mux), 0);
    check("rst_dato", 32'(dato), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(err), 0);
    check("rst_shadow0", 32'(shadow0), 32'h80);
    check("rst_shadow1", 32'(shadow1), 32'h80);
    check("rst_shadow2", 32'(shadow2), 32'h80);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(cmd_ready), 1);

    // Single write: latency, shadow update, busy.
    expect_wr(2'd1, 8'h55);
    send_cmd(2'd1, 8'h55);
    check("w1_shadow1", 32'(shadow1), 32'h55);
    check("w1_busy", 32'(busy), 1);
    check("w1_mux", 32'(mux), 1);
    check("w1_dato", 32'(dato), 32'h55);
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (!ctrl) begin
        lat = k;
        break;
      end
    end
    check("w1_latency", lat, 3);
    wait_ready();
    check("w1_busy_done", 32'(busy), 0);

    // Illegal select, then err_clr, then err_clr beating a simultaneous illegal accept.
    send_cmd(2'd3, 8'hAA);
    check("ill_err", 32'(err), 1);
    check("ill_busy", 32'(busy), 0);
    check("ill_shadow0", 32'(shadow0), 32'h80);
    check("ill_shadow1", 32'(shadow1), 32'h55);
    check("ill_shadow2", 32'(shadow2), 32'h80);
    repeat (10) @(negedge clk);
    check("ill_ctrl", 32'(ctrl), 1);
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    check("err_clr", 32'(err), 0);
    wait_ready();
    cmd_valid = 1'b1; cmd_sel = 2'd3; cmd_data = 8'h01; err_clr = 1'b1;
    @(posedge clk);
    #1 begin cmd_valid = 1'b0; err_clr = 1'b0; end
    check("err_clr_priority", 32'(err), 0);

    // Load 11/22/33, then a refresh rewrites all three in order.
    expect_wr(2'd0, 8'h11); send_cmd(2'd0, 8'h11);
    expect_wr(2'd1, 8'h22); send_cmd(2'd1, 8'h22);
    expect_wr(2'd2, 8'h33); send_cmd(2'd2, 8'h33);
    wait_ready();
    high_q.delete();
    expect_wr(2'd0, 8'h11);
    expect_wr(2'd1, 8'h22);
    expect_wr(2'd2, 8'h33);
    pulse_refresh();
    wait_ready();
    check("refr_pulses", high_q.size(), 3);
    if (high_q.size() >= 3) begin
      check("refr_gap1", high_q[1], 6);
      check("refr_gap2", high_q[2], 6);
    end

    // Refresh and command in the same IDLE cycle: command first, then refresh with the new value.
    wait_ready();
    expect_wr(2'd0, 8'h10);
    expect_wr(2'd0, 8'h10);
    expect_wr(2'd1, 8'h22);
    expect_wr(2'd2, 8'h33);
    cmd_valid = 1'b1; cmd_sel = 2'd0; cmd_data = 8'h10; refresh = 1'b1;
    @(posedge clk);
    #1 begin cmd_valid = 1'b0; refresh = 1'b0; end
    wait_ready();
    check("simul_shadow0", 32'(shadow0), 32'h10);

    // Two refresh pulses during a refresh merge into one extra pass.
    for (int p = 0; p < 2; p++) begin
      expect_wr(2'd0, 8'h10);
      expect_wr(2'd1, 8'h22);
      expect_wr(2'd2, 8'h33);
    end
    pulse_refresh();
    repeat (60) @(negedge clk);
    pulse_refresh();
    repeat (30) @(negedge clk);
    pulse_refresh();
    wait_ready();
    check("merge_drained", exp_q.size(), 0);

    // Reset in the middle of a transfer.
    expect_wr(2'd0, 8'h77);
    send_cmd(2'd0, 8'h77);
    n = 0;
    while (ctrl && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mid_xfer_low", 32'(ctrl), 0);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_ctrl", 32'(ctrl), 1);
    check("async_ready", 32'(cmd_ready), 0);
    check("async_shadow0", 32'(shadow0), 32'h80);
    check("async_shadow1", 32'(shadow1), 32'h80);
    check("async_shadow2", 32'(shadow2), 32'h80);
    repeat (2) @(negedge clk);
    check("rst_held_ready", 32'(cmd_ready), 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst2", 32'(cmd_ready), 1);

    // Command equal to the current shadow value.
`ifdef DIGIPOT_SKIP_SAME_EN
    send_cmd(2'd2, 8'h80);
    saw = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (busy || !ctrl) saw = 1'b1;
    end
    check("skip_no_write", 32'(saw), 0);
`else
    expect_wr(2'd2, 8'h80);
    send_cmd(2'd2, 8'h80);
    check("same_busy", 32'(busy), 1);
    saw = 1'b0;
`endif
    check("same_shadow2", 32'(shadow2), 32'h80);

    wait_ready();
    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
